// File: rtl/tt_scan_pkg.sv
// tt_scan_pkg: shared FSM state encoding and per-design slot width for the scan controller
package tt_scan_pkg;
  localparam int BITS_PER_DESIGN = 8;
  typedef enum logic [2:0] {S_IDLE, S_CAPTURE, S_SHIFT, S_LATCH, S_DONE} state_t;
endpackage

// File: rtl/tt_scan_clkgen.sv
// tt_scan_clkgen: scan-clock phase generator, low for CLK_DIV cycles then high for CLK_DIV cycles
module tt_scan_clkgen #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  output logic sc_clk,
  output logic pulse_start,
  output logic rise,
  output logic pulse_end
);
  localparam int W = $clog2(2 * CLK_DIV);
  localparam logic [W-1:0] HALF = W'(CLK_DIV);
  localparam logic [W-1:0] LAST = W'(2 * CLK_DIV - 1);
  logic [W-1:0] cnt;
  // phase counter restarts every pulse and idles at zero while disabled
  always_ff @(posedge clk)
    if (rst || !enable) cnt <= '0;
    else cnt <= pulse_end ? '0 : cnt + 1'b1;
  // phase decode: level plus strobes at pulse start, rising edge and last cycle
  always_comb begin
    sc_clk = enable && cnt >= HALF;
    pulse_start = enable && cnt == '0;
    rise = enable && cnt == HALF;
    pulse_end = enable && cnt == LAST;
  end
endmodule

// File: rtl/tt_scan_ctrl.sv
// tt_scan_ctrl: runs one capture/shift/latch transfer on a scan chain of 8-bit design slots
module tt_scan_ctrl
  import tt_scan_pkg::*;
#(
  parameter int NUM_DESIGNS = 8,
  parameter int CLK_DIV = 2
) (
  input  logic                           wb_clk_i,
  input  logic                           wb_rst_i,
  input  logic                           start,
  input  logic [$clog2(NUM_DESIGNS)-1:0] sel,
  input  logic [7:0]                     in_data,
  output logic [7:0]                     out_data,
  output logic                           busy,
  output logic                           done,
  output logic                           sc_clk_out,
  output logic                           sc_data_out,
  output logic                           sc_scan_select,
  output logic                           sc_latch_en,
  input  logic                           sc_data_in
);
  localparam int T = NUM_DESIGNS * BITS_PER_DESIGN;
  localparam int KW = $clog2(T + 1);
  localparam logic [KW-1:0] LAST_K = KW'(T - 1);
  state_t state, nxt;
  logic [$clog2(NUM_DESIGNS)-1:0] sel_q;
  logic [7:0] in_q, cap;
  logic [KW-1:0] k;
  logic [KW-4:0] slot;
  logic run, valid, accept, out_hit, in_hit;
  logic sc_clk, pulse_start, rise, pulse_end;
  assign run = state == S_CAPTURE || state == S_SHIFT || state == S_LATCH;
  assign valid = int'(sel) < NUM_DESIGNS;
  assign accept = state == S_IDLE && start && valid;
  assign slot = k[KW-1:3];
  assign out_hit = int'(slot) == NUM_DESIGNS - 1 - int'(sel_q);
  assign in_hit = int'(slot) == int'(sel_q);
  tt_scan_clkgen #(.CLK_DIV(CLK_DIV)) u_clkgen (
    .clk(wb_clk_i),
    .rst(wb_rst_i),
    .enable(run),
    .sc_clk(sc_clk),
    .pulse_start(pulse_start),
    .rise(rise),
    .pulse_end(pulse_end)
  );
  // state register
  always_ff @(posedge wb_clk_i)
    if (wb_rst_i) state <= S_IDLE;
    else state <= nxt;
  // next state and chain-side outputs; every phase change lands on a pulse boundary
  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:    nxt = !start ? S_IDLE : valid ? S_CAPTURE : S_DONE;
      S_CAPTURE: nxt = pulse_end ? S_SHIFT : S_CAPTURE;
      S_SHIFT:   nxt = pulse_end && k == LAST_K ? S_LATCH : S_SHIFT;
      S_LATCH:   nxt = pulse_end ? S_DONE : S_LATCH;
      default:   nxt = S_IDLE;
    endcase
    busy = run;
    done = state == S_DONE;
    sc_clk_out = sc_clk && state != S_LATCH;
    sc_scan_select = state == S_CAPTURE;
    sc_latch_en = state == S_LATCH;
    sc_data_out = state == S_SHIFT && out_hit && in_q[~k[2:0]];
  end
  // request latch, shift index, capture shadow and result publish on completion
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      sel_q <= '0;
      in_q <= '0;
      cap <= '0;
      k <= '0;
      out_data <= '0;
    end else begin
      if (accept) begin
        sel_q <= sel;
        in_q <= in_data;
      end
      if (state == S_CAPTURE && pulse_start) cap <= '0;
      if (state == S_SHIFT && rise && in_hit) cap[~k[2:0]] <= sc_data_in;
      k <= state != S_SHIFT ? '0 : pulse_end ? k + 1'b1 : k;
      if (state == S_LATCH && pulse_end) out_data <= cap;
    end
  end
endmodule

// File: tb/tb_tt_scan_ctrl.sv
// tb_tt_scan_ctrl: directed and randomized checks of tt_scan_ctrl against a slot-level chain model
module tb_tt_scan_ctrl;
  localparam int N = 8;
  localparam int T = N * 8;
  logic clk = 1'b0, rst = 1'b1;
  logic start = 1'b0, sdi = 1'b0;
  logic [2:0] sel = '0;
  logic [7:0] in_data = '0;
  logic [7:0] out_data;
  logic busy, done, sc_clk_out, sc_data_out, sc_scan_select, sc_latch_en;
  logic start2 = 1'b0, sel2 = 1'b0, sdi2 = 1'b1;
  logic [7:0] in2 = '0, out2;
  logic busy2, done2, sck2, sdo2, ssel2, latch2;
  logic start3 = 1'b0, sdi3 = 1'b1;
  logic [1:0] sel3 = '0;
  logic [7:0] in3 = '0, out3;
  logic busy3, done3, sck3, sdo3, ssel3, latch3;

  int n_chk = 0, n_fail = 0;
  logic [7:0] slot_out[N];
  logic [7:0] slot_in[N];
  logic [T-1:0] sent = '0;
  int kb = 0, latch_pulses = 0, edges3 = 0;
  logic prev_clk = 1'b0, prev_latch = 1'b0, prev3 = 1'b0;
  int hi2 = 0, hi_min2 = 1000, hi_max2 = 0, lat2 = 0, lat_last2 = 0;

  always #5 clk = ~clk;

  tt_scan_ctrl #(.NUM_DESIGNS(N), .CLK_DIV(2)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .start(start), .sel(sel), .in_data(in_data),
    .out_data(out_data), .busy(busy), .done(done), .sc_clk_out(sc_clk_out),
    .sc_data_out(sc_data_out), .sc_scan_select(sc_scan_select),
    .sc_latch_en(sc_latch_en), .sc_data_in(sdi)
  );
  tt_scan_ctrl #(.NUM_DESIGNS(2), .CLK_DIV(1)) u2 (
    .wb_clk_i(clk), .wb_rst_i(rst), .start(start2), .sel(sel2), .in_data(in2),
    .out_data(out2), .busy(busy2), .done(done2), .sc_clk_out(sck2),
    .sc_data_out(sdo2), .sc_scan_select(ssel2), .sc_latch_en(latch2), .sc_data_in(sdi2)
  );
  tt_scan_ctrl #(.NUM_DESIGNS(3), .CLK_DIV(1)) u3 (
    .wb_clk_i(clk), .wb_rst_i(rst), .start(start3), .sel(sel3), .in_data(in3),
    .out_data(out3), .busy(busy3), .done(done3), .sc_clk_out(sck3),
    .sc_data_out(sdo3), .sc_scan_select(ssel3), .sc_latch_en(latch3), .sc_data_in(sdi3)
  );

  // chain model: slot s returns its byte MSB-first at shift pulses 8s..8s+7;
  // bits sent at pulses 8(N-1-j)..+7 end up latched into slot j, MSB-first
  always @(negedge clk) begin
    if (sc_scan_select) begin
      kb = 0;
      sent = '0;
    end
    sdi = kb < T ? slot_out[kb / 8][7 - kb % 8] : 1'b0;
    if (busy && !sc_scan_select && sc_clk_out && !prev_clk && kb < T) begin
      sent[kb] = sc_data_out;
      kb++;
    end
    if (sc_latch_en && !prev_latch) begin
      latch_pulses++;
      for (int j = 0; j < N; j++)
        for (int i = 0; i < 8; i++) slot_in[j][7 - i] = sent[8 * (N - 1 - j) + i];
    end
    prev_clk = sc_clk_out;
    prev_latch = sc_latch_en;
  end

  // phase-length and edge observers for the small instances
  always @(negedge clk) begin
    if (sck2) hi2++;
    else begin
      if (hi2 > 0) begin
        hi_min2 = hi2 < hi_min2 ? hi2 : hi_min2;
        hi_max2 = hi2 > hi_max2 ? hi2 : hi_max2;
      end
      hi2 = 0;
    end
    if (latch2) lat2++;
    else begin
      if (lat2 > 0) lat_last2 = lat2;
      lat2 = 0;
    end
    if (sck3 !== prev3) edges3++;
    prev3 = sck3;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic xfer(input logic [2:0] s, input logic [7:0] d, output int bc, output bit got);
    @(negedge clk);
    sel = s;
    in_data = d;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    bc = 0;
    got = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (done) begin
        got = 1'b1;
        break;
      end
      if (busy) bc++;
      sel = 3'($urandom);
      in_data = 8'($urandom);
      start = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  initial begin
    int bc, n_done, n_rise, t_rise1, t_rise2, t_done1, lp0, e0;
    bit got, pb;
    logic [2:0] s;
    logic [7:0] d;
    for (int j = 0; j < N; j++) slot_out[j] = '0;
    repeat (3) @(negedge clk);
    chk("reset_dut", {out_data, busy, done, sc_clk_out, sc_data_out, sc_scan_select, sc_latch_en}, 0);
    chk("reset_u2", {out2, busy2, done2, sck2, sdo2, ssel2, latch2}, 0);
    chk("reset_u3", {out3, busy3, done3, sck3, sdo3, ssel3, latch3}, 0);
    rst = 1'b0;
    for (int j = 0; j < N; j++) slot_out[j] = 8'($urandom);
    slot_out[3] = 8'hA5;
    xfer(3'd3, 8'h3C, bc, got);
    chk("a5_done", got, 1);
    chk("a5_busy", bc, 264);
    chk("a5_out", out_data, 8'hA5);
    chk("a5_busy_in_done", busy, 0);
    for (int j = 0; j < N; j++) chk("a5_slot_in", slot_in[j], j == 3 ? 8'h3C : 8'h00);
    @(negedge clk);
    chk("done_width", done, 0);
    chk("out_hold", out_data, 8'hA5);
    for (int r = 0; r < 4; r++) begin
      for (int j = 0; j < N; j++) slot_out[j] = 8'($urandom);
      s = 3'($urandom_range(0, N - 1));
      d = 8'($urandom);
      xfer(s, d, bc, got);
      chk("rand_done", got, 1);
      chk("rand_busy", bc, 264);
      chk("rand_out", out_data, slot_out[s]);
      chk("rand_latch", slot_in[s], d);
    end
    xfer(3'd7, 8'h80, bc, got);
    chk("msb_done", got, 1);
    chk("msb_sent", sent, 64'h1);
    for (int j = 0; j < N; j++) slot_out[j] = 8'($urandom);
    @(negedge clk);
    sel = 3'd2;
    in_data = 8'h5A;
    start = 1'b1;
    n_done = 0; n_rise = 0; t_rise1 = -1; t_rise2 = -1; t_done1 = -1; pb = 1'b0;
    for (int c = 1; c <= 700; c++) begin
      @(negedge clk);
      if (c == 300) start = 1'b0;
      if (busy && !pb) begin
        n_rise++;
        if (n_rise == 1) t_rise1 = c;
        if (n_rise == 2) t_rise2 = c;
      end
      if (done) begin
        n_done++;
        if (n_done == 1) t_done1 = c;
      end
      pb = busy;
    end
    chk("hold_transfers", n_rise, 2);
    chk("hold_dones", n_done, 2);
    chk("hold_first", t_rise1, 1);
    chk("hold_gap", t_rise2 - t_done1, 2);
    chk("hold_out", out_data, slot_out[2]);
    @(negedge clk);
    sel = 3'($urandom_range(0, N - 1));
    in_data = 8'($urandom);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (99) @(negedge clk);
    chk("abort_busy_before", busy, 1);
    lp0 = latch_pulses;
    rst = 1'b1;
    @(negedge clk);
    chk("abort_outputs", {out_data, busy, done, sc_clk_out, sc_data_out, sc_scan_select, sc_latch_en}, 0);
    rst = 1'b0;
    n_done = 0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (done || busy) n_done++;
    end
    chk("abort_no_done", n_done, 0);
    chk("abort_no_latch", latch_pulses, lp0);
    for (int j = 0; j < N; j++) slot_out[j] = 8'($urandom);
    xfer(3'd0, 8'hFF, bc, got);
    chk("after_abort_done", got, 1);
    chk("after_abort_busy", bc, 264);
    chk("after_abort_out", out_data, slot_out[0]);
    chk("after_abort_latch", slot_in[0], 8'hFF);
    @(negedge clk);
    sel2 = 1'b1;
    in2 = 8'($urandom);
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    bc = 0;
    got = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (done2) begin
        got = 1'b1;
        break;
      end
      if (busy2) bc++;
      @(negedge clk);
    end
    @(negedge clk);
    chk("small_done", got, 1);
    chk("small_busy", bc, 36);
    chk("small_out", out2, 8'hFF);
    chk("small_hi_min", hi_min2, 1);
    chk("small_hi_max", hi_max2, 1);
    chk("small_latch", lat_last2, 2);
    @(negedge clk);
    sel3 = 2'd1;
    start3 = 1'b1;
    @(negedge clk);
    start3 = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (done3) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("n3_done", got, 1);
    chk("n3_out", out3, 8'hFF);
    repeat (2) @(negedge clk);
    e0 = edges3;
    sel3 = 2'd3;
    start3 = 1'b1;
    @(negedge clk);
    start3 = 1'b0;
    chk("badsel_done", done3, 1);
    chk("badsel_busy", busy3, 0);
    chk("badsel_out", out3, 8'hFF);
    @(negedge clk);
    chk("badsel_done_width", done3, 0);
    chk("badsel_busy_after", busy3, 0);
    repeat (5) @(negedge clk);
    chk("badsel_no_edges", edges3, e0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
